// File: rtl/gray_seq_pkg.sv
// gray_seq_pkg: shared definitions for the Gray-coded position sequencer.
//   - command op encodings (HOLD/INC/DEC/SEEK)
//   - control FSM state enum (IDLE/SEEK/DONE)
//   - bin2gray / gray2bin helpers. They work on a MAX_W-bit container and
//     take the active width as an argument, so callers of any width up to
//     MAX_W zero-extend on the way in and truncate on the way out.
package gray_seq_pkg;

  localparam int unsigned MAX_W = 32;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_DONE
  } seq_state_e;

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    logic [MAX_W-1:0] m;
    if (w >= MAX_W) m = '1;
    else            m = (MAX_W'(1) << w) - MAX_W'(1);
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                input int unsigned     w);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int unsigned     w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(w);
    b  = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_decode.sv
// gray_seq_decode: combinational decode of a Gray-coded position.
//   state_gray  in   STATE_W  Gray-coded position
//   state_idx   out  STATE_W  binary index of state_gray
//   onehot      out  OUT_W    bit (state_idx mod OUT_W) set, others clear
// OUT_W must be a power of two, 2 <= OUT_W <= 2^STATE_W, so the modulo is
// just the low $clog2(OUT_W) index bits.
module gray_seq_decode
  import gray_seq_pkg::*;
#(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned OUT_W   = 8
) (
  input  logic [STATE_W-1:0] state_gray,
  output logic [STATE_W-1:0] state_idx,
  output logic [OUT_W-1:0]   onehot
);

  localparam int unsigned SEL_W = $clog2(OUT_W);

  always_comb begin
    state_idx = STATE_W'(gray2bin(MAX_W'(state_gray), STATE_W));
    onehot    = '0;
    onehot[state_idx[SEL_W-1:0]] = 1'b1;
  end

endmodule

// File: rtl/gray_seq.sv
// gray_seq: Gray-coded position sequencer with handshaked commands.
//   clk, rst     clock; synchronous active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  sequencer can accept a command (IDLE only)
//   cmd_op       in   00 HOLD, 01 INC, 10 DEC, 11 SEEK
//   cmd_target   in   binary seek target, sampled at acceptance only
//   state_gray   out  registered Gray-coded position
//   state_idx    out  binary index of state_gray
//   onehot       out  bit (state_idx mod OUT_W) set
//   busy         out  seek in progress
//   done         out  one-cycle pulse when a seek completes
//   edge_evt     out  one-cycle pulse on wrap (WRAP=1) or blocked end step (WRAP=0)
// Position arithmetic is done in binary and re-encoded to Gray for storage;
// a +/-1 binary step always maps to a single Gray bit flip, wrap included.
module gray_seq
  import gray_seq_pkg::*;
#(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned WRAP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [STATE_W-1:0] cmd_target,
  output logic [STATE_W-1:0] state_gray,
  output logic [STATE_W-1:0] state_idx,
  output logic [OUT_W-1:0]   onehot,
  output logic               busy,
  output logic               done,
  output logic               edge_evt
);

  localparam logic [STATE_W-1:0] IDX_MAX = '1;
  localparam logic [STATE_W-1:0] IDX_MIN = '0;

  seq_state_e         state_q;
  logic [STATE_W-1:0] gray_q;
  logic [STATE_W-1:0] target_q;
  logic [STATE_W-1:0] idx;
  logic [STATE_W-1:0] idx_up;
  logic [STATE_W-1:0] idx_dn;
  logic [STATE_W-1:0] gray_up;
  logic [STATE_W-1:0] gray_dn;
  logic               accept;

  gray_seq_decode #(
    .STATE_W (STATE_W),
    .OUT_W   (OUT_W)
  ) u_decode (
    .state_gray (gray_q),
    .state_idx  (idx),
    .onehot     (onehot)
  );

  assign state_gray = gray_q;
  assign state_idx  = idx;
  assign accept     = cmd_valid && cmd_ready;

  // Neighbour positions; binary wrap-around gives the max<->0 wrap for free.
  always_comb begin
    idx_up  = idx + STATE_W'(1);
    idx_dn  = idx - STATE_W'(1);
    gray_up = STATE_W'(bin2gray(MAX_W'(idx_up), STATE_W));
    gray_dn = STATE_W'(bin2gray(MAX_W'(idx_dn), STATE_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gray_q    <= '0;
      target_q  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      edge_evt  <= 1'b0;
    end else begin
      done     <= 1'b0;
      edge_evt <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_INC: begin
                if (idx == IDX_MAX) begin
                  edge_evt <= 1'b1;
                  if (WRAP != 0) gray_q <= gray_up;
                end else begin
                  gray_q <= gray_up;
                end
              end
              OP_DEC: begin
                if (idx == IDX_MIN) begin
                  edge_evt <= 1'b1;
                  if (WRAP != 0) gray_q <= gray_dn;
                end else begin
                  gray_q <= gray_dn;
                end
              end
              OP_SEEK: begin
                target_q  <= cmd_target;
                state_q   <= ST_SEEK;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_SEEK: begin
          // Step toward the target; completion is flagged on the edge that
          // lands on it, or immediately when already there.
          if (target_q > idx) begin
            gray_q <= gray_up;
            if (idx_up == target_q) begin
              state_q <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else if (target_q < idx) begin
            gray_q <= gray_dn;
            if (idx_dn == target_q) begin
              state_q <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state_q   <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
